// File: rtl/board_draw_sequencer.sv
// Tile-map walker that feeds the sprite drawer one 8x8 tile request at a time.
// Optional feature macro: BOARD_SEQ_DIRTY_EN (redraw only cells written since their last draw).
module board_draw_sequencer #(
   parameter int COLS        = 8,
   parameter int ROWS        = 8,
   parameter int TILE        = 8,
   parameter int X0          = 0,
   parameter int Y0          = 0,
   parameter int GO_CYCLES   = 2,
   parameter int DRAW_CYCLES = 68
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_col,
   input  logic [2:0] wr_row,
   input  logic [2:0] wr_id,
   input  logic       redraw,
   output logic       busy,
   output logic       frame_done,
   output logic [7:0] draw_x,
   output logic [6:0] draw_y,
   output logic [2:0] draw_id,
   output logic       draw_go
);
   // state | meaning
   // IDLE  | waiting for redraw
   // SCAN  | one cycle per cell: latch tile request or skip the cell
   // GO    | draw_go high for GO_CYCLES
   // WAIT  | drawer busy for DRAW_CYCLES
   // DONE  | one-cycle frame_done
   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_GO, S_WAIT, S_DONE} state_t;

   localparam int N     = COLS * ROWS;
   localparam int IDX_W = $clog2(N);
   localparam int TMAX  = (GO_CYCLES > DRAW_CYCLES) ? GO_CYCLES : DRAW_CYCLES;
   localparam int TMR_W = $clog2(TMAX + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [7:0]        draw_x_q, draw_x_d;
   logic [6:0]        draw_y_q, draw_y_d;
   logic [2:0]        draw_id_q, draw_id_d;
   logic [2:0]        map_q [N];
   logic [2:0]        map_d [N];
   logic [IDX_W-1:0]  wr_idx;
   logic              sel;
`ifdef BOARD_SEQ_DIRTY_EN
   logic [N-1:0]      dirty_q, dirty_d;
`endif

   assign wr_idx = IDX_W'(int'(wr_row) * COLS + int'(wr_col));

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      timer_d   = timer_q;
      draw_x_d  = draw_x_q;
      draw_y_d  = draw_y_q;
      draw_id_d = draw_id_q;
      map_d     = map_q;
`ifdef BOARD_SEQ_DIRTY_EN
      dirty_d   = dirty_q;
      sel       = dirty_q[idx_q];
`else
      sel       = 1'b1;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (redraw) begin
               state_d = S_SCAN;
               idx_d   = '0;
            end
         end
         S_SCAN: begin
            if (sel) begin
               draw_x_d  = 8'(X0 + (int'(idx_q) % COLS) * TILE);
               draw_y_d  = 7'(Y0 + (int'(idx_q) / COLS) * TILE);
               draw_id_d = map_q[idx_q];
               timer_d   = TMR_W'(GO_CYCLES - 1);
               state_d   = S_GO;
`ifdef BOARD_SEQ_DIRTY_EN
               dirty_d[idx_q] = 1'b0;
`endif
            end else if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_GO: begin
            if (timer_q == '0) begin
               timer_d = TMR_W'(DRAW_CYCLES - 1);
               state_d = S_WAIT;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_WAIT: begin
            if (timer_q != '0) begin
               timer_d = timer_q - 1'b1;
            end else if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_SCAN;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Write applied after the scan clear so a same-cycle write re-dirties the cell.
      if (wr_en) begin
         map_d[wr_idx] = wr_id;
`ifdef BOARD_SEQ_DIRTY_EN
         dirty_d[wr_idx] = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         timer_q   <= '0;
         draw_x_q  <= '0;
         draw_y_q  <= '0;
         draw_id_q <= '0;
         for (int i = 0; i < N; i++) map_q[i] <= '0;
`ifdef BOARD_SEQ_DIRTY_EN
         dirty_q   <= '1;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         timer_q   <= timer_d;
         draw_x_q  <= draw_x_d;
         draw_y_q  <= draw_y_d;
         draw_id_q <= draw_id_d;
         map_q     <= map_d;
`ifdef BOARD_SEQ_DIRTY_EN
         dirty_q   <= dirty_d;
`endif
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_DONE);
   assign draw_go    = (state_q == S_GO);
   assign draw_x     = draw_x_q;
   assign draw_y     = draw_y_q;
   assign draw_id    = draw_id_q;
endmodule

// File: tb/tb_board_draw_sequencer.sv
// Bench for board_draw_sequencer: cycle-cost model of the walk plus directed walks.
module tb_board_draw_sequencer;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [2:0] wr_col = '0, wr_row = '0, wr_id = '0;
   logic       redraw = 1'b0;
   logic       busy, frame_done, draw_go;
   logic [7:0] draw_x;
   logic [6:0] draw_y;
   logic [2:0] draw_id;

   localparam int REQ_COST = 1 + 2 + 68;

   always #5 clk = ~clk;

   board_draw_sequencer dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row),
      .wr_id(wr_id), .redraw(redraw), .busy(busy), .frame_done(frame_done),
      .draw_x(draw_x), .draw_y(draw_y), .draw_id(draw_id), .draw_go(draw_go)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a walk is a sequence of cells, each costing REQ_COST cycles if drawn or 1 if skipped.
   bit m_active = 0, m_done = 0;
   int m_cell = 0, m_phase = 0, m_cost = 1;
   int m_x = 0, m_y = 0, m_id = 0;
   int m_map [64];
   bit m_dirty [64];

   always @(posedge clk) begin
      bit sel;
      if (reset) begin
         m_active = 0; m_done = 0; m_cell = 0; m_phase = 0;
         m_x = 0; m_y = 0; m_id = 0;
         for (int i = 0; i < 64; i++) begin m_map[i] = 0; m_dirty[i] = 1; end
      end else begin
         if (m_done) begin
            m_done = 0;
         end else if (m_active) begin
            if (m_phase == 0) begin
`ifdef BOARD_SEQ_DIRTY_EN
               sel = m_dirty[m_cell];
`else
               sel = 1;
`endif
               m_cost = sel ? REQ_COST : 1;
               if (sel) begin
                  m_x = (m_cell % 8) * 8;
                  m_y = (m_cell / 8) * 8;
                  m_id = m_map[m_cell];
                  m_dirty[m_cell] = 0;
               end
            end
            m_phase++;
            if (m_phase == m_cost) begin
               if (m_cell == 63) begin m_active = 0; m_done = 1; end
               else begin m_cell++; m_phase = 0; end
            end
         end else if (redraw) begin
            m_active = 1; m_cell = 0; m_phase = 0;
         end
         if (wr_en) begin
            m_map[int'(wr_row) * 8 + int'(wr_col)] = int'(wr_id);
            m_dirty[int'(wr_row) * 8 + int'(wr_col)] = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, m_active || m_done);
         chk("frame_done", frame_done, m_done);
         chk("draw_go", draw_go, m_active && m_phase >= 1 && m_phase <= 2 && m_cost == REQ_COST);
         chk("draw_x", draw_x, m_x);
         chk("draw_y", draw_y, m_y);
         chk("draw_id", draw_id, m_id);
      end
   end

   int req_cnt, done_cyc, done_cnt;
   int rq_x [81];
   int rq_y [81];
   int rq_id [81];

   task automatic write_cell(input int c, input int r, input int id);
      wr_en = 1; wr_col = 3'(c); wr_row = 3'(r); wr_id = 3'(id);
      @(negedge clk);
      wr_en = 0;
   endtask

   // Redraw issued in cycle 0; cycle n is observed at the negedge after n edges.
   task automatic run_walk(input int limit, input int w0_en, input int w0c, input int w0r,
                           input int w0i, input int w1_at, input int w1c, input int w1r,
                           input int w1i, input int w2_at, input int w2c, input int w2r,
                           input int w2i, input int rd1, input int rd2, input int rst_at);
      int n;
      bit prev_go;
      req_cnt = 0; done_cyc = -1; done_cnt = 0; prev_go = 0;
      redraw = 1;
      if (w0_en != 0) begin wr_en = 1; wr_col = 3'(w0c); wr_row = 3'(w0r); wr_id = 3'(w0i); end
      @(negedge clk);
      n = 1;
      while (n <= limit) begin
         if (draw_go && !prev_go) begin
            req_cnt++;
            if (req_cnt <= 80) begin
               rq_x[req_cnt] = int'(draw_x); rq_y[req_cnt] = int'(draw_y);
               rq_id[req_cnt] = int'(draw_id);
            end
         end
         prev_go = draw_go;
         if (frame_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = n;
         end
         if (n == rst_at + 1) begin
            chk("rst_busy", busy, 0);
            chk("rst_go", draw_go, 0);
         end
         redraw = (n == rd1) || (n == rd2);
         reset = (n == rst_at);
         wr_en = 0;
         if (n == w1_at) begin wr_en = 1; wr_col = 3'(w1c); wr_row = 3'(w1r); wr_id = 3'(w1i); end
         if (n == w2_at) begin wr_en = 1; wr_col = 3'(w2c); wr_row = 3'(w2r); wr_id = 3'(w2i); end
         if (done_cyc >= 0 && n >= done_cyc + 150) break;
         @(negedge clk);
         n++;
      end
      redraw = 0; wr_en = 0; reset = 0;
   endtask

   initial begin
      reset = 1;
      @(negedge clk);
      chk_en = 1;
      repeat (2) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset draw_go", draw_go, 0);
      chk("reset draw_x", draw_x, 0);
      chk("reset draw_y", draw_y, 0);
      chk("reset draw_id", draw_id, 0);
      chk("reset frame_done", frame_done, 0);
      reset = 0;
      repeat (2) @(negedge clk);

      // Reset during WAIT of request #10 aborts the walk and clears the map.
      write_cell(2, 3, 5);
      run_walk(800, 1, 4, 5, 3, -1, 0, 0, 0, -1, 0, 0, 0, -1, -1, 650);
      chk("abort requests", req_cnt, 10);
      chk("abort frame_done count", done_cnt, 0);
      chk("abort busy", busy, 0);
      repeat (3) @(negedge clk);

      // Full walk with mid-request write, write behind the walk, and ignored redraws.
      write_cell(2, 3, 5);
      run_walk(6000, 0, 0, 0, 0, 730, 2, 1, 7, 2000, 3, 0, 6, 100, 2000, -1);
      chk("walk1 requests", req_cnt, 64);
      chk("walk1 done cycle", done_cyc, 4545);
      chk("walk1 done count", done_cnt, 1);
      chk("walk1 req27 x", rq_x[27], 16);
      chk("walk1 req27 y", rq_y[27], 24);
      chk("walk1 req27 id", rq_id[27], 5);
      chk("walk1 req11 id", rq_id[11], 0);
      chk("walk1 req45 id", rq_id[45], 0);
      chk("walk1 idle after", busy, 0);

      // Second walk picks up cells written during the first.
      run_walk(6000, 0, 0, 0, 0, -1, 0, 0, 0, -1, 0, 0, 0, -1, -1, -1);
`ifdef BOARD_SEQ_DIRTY_EN
      chk("walk2 requests", req_cnt, 2);
      chk("walk2 done cycle", done_cyc, 205);
      chk("walk2 req1 id", rq_id[1], 6);
      chk("walk2 req2 id", rq_id[2], 7);
`else
      chk("walk2 requests", req_cnt, 64);
      chk("walk2 done cycle", done_cyc, 4545);
      chk("walk2 req4 id", rq_id[4], 6);
      chk("walk2 req11 id", rq_id[11], 7);
`endif

      // Write and redraw in the same IDLE cycle.
      run_walk(6000, 1, 7, 7, 4, -1, 0, 0, 0, -1, 0, 0, 0, -1, -1, -1);
`ifdef BOARD_SEQ_DIRTY_EN
      chk("walk3 requests", req_cnt, 1);
      chk("walk3 done cycle", done_cyc, 135);
`else
      chk("walk3 requests", req_cnt, 64);
      chk("walk3 done cycle", done_cyc, 4545);
`endif
      chk("walk3 last x", rq_x[req_cnt], 56);
      chk("walk3 last y", rq_y[req_cnt], 56);
      chk("walk3 last id", rq_id[req_cnt], 4);

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
